// File: rtl/writeback_select_if.sv
// Writeback stage bus: upstream entry fields plus downstream register-file write port.
// Handshake: a side transfers on a rising clk edge where valid && ready; a producer holds valid and its fields stable until that edge.
interface writeback_select_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4
);
    localparam int OFF_WIDTH = $clog2(DATA_WIDTH / 8);

    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                wb_src;
    logic [1:0]                load_size;
    logic                      load_signed;
    logic [OFF_WIDTH-1:0]      byte_offset;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     read_data;
    logic [DATA_WIDTH-1:0]     link_addr;
    logic [DATA_WIDTH-1:0]     imm_value;
    logic [REG_ADDR_WIDTH-1:0] dest_reg;
    logic                      reg_write_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [REG_ADDR_WIDTH-1:0] write_reg;
    logic                      write_en;

    modport master (
        output in_valid, wb_src, load_size, load_signed, byte_offset,
               alu_result, read_data, link_addr, imm_value, dest_reg,
               reg_write_in, out_ready,
        input  in_ready, out_valid, write_data, write_reg, write_en
    );

    modport slave (
        input  in_valid, wb_src, load_size, load_signed, byte_offset,
               alu_result, read_data, link_addr, imm_value, dest_reg,
               reg_write_in, out_ready,
        output in_ready, out_valid, write_data, write_reg, write_en
    );
endinterface

// File: rtl/writeback_select.sv
// Writeback select/extract stage with a registered output and a one-entry skid buffer.
// in_ready depends only on skid occupancy and rst, never on out_ready.
module writeback_select #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    writeback_select_if.slave bus
);
    localparam int OFF_WIDTH = $clog2(DATA_WIDTH / 8);

    logic [7:0]                byte_lane;
    logic [15:0]               half_lane;
    logic [OFF_WIDTH-1:0]      half_idx;
    logic [DATA_WIDTH-1:0]     new_data;
    logic                      new_we;
    logic                      in_xfer;
    logic                      out_load;

    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]     out_data_q,  out_data_d;
    logic [REG_ADDR_WIDTH-1:0] out_reg_q,   out_reg_d;
    logic                      out_we_q,    out_we_d;
    logic                      skid_full_q, skid_full_d;
    logic [DATA_WIDTH-1:0]     skid_data_q, skid_data_d;
    logic [REG_ADDR_WIDTH-1:0] skid_reg_q,  skid_reg_d;
    logic                      skid_we_q,   skid_we_d;

    // Half-word lanes are indexed by the offset with its LSB dropped.
    always_comb begin
        half_idx  = bus.byte_offset >> 1;
        byte_lane = bus.read_data[8*int'(bus.byte_offset) +: 8];
        half_lane = bus.read_data[16*int'(half_idx) +: 16];
        new_data  = bus.alu_result;
        unique case (bus.wb_src)
            2'd0: new_data = bus.alu_result;
            2'd1: begin
                unique case (bus.load_size)
                    2'd0:    new_data = {{(DATA_WIDTH-8){bus.load_signed & byte_lane[7]}}, byte_lane};
                    2'd1:    new_data = {{(DATA_WIDTH-16){bus.load_signed & half_lane[15]}}, half_lane};
                    default: new_data = bus.read_data;
                endcase
            end
            2'd2:    new_data = bus.link_addr;
            default: new_data = bus.imm_value;
        endcase
    end

    assign new_we       = bus.reg_write_in & (bus.dest_reg != '0);
    assign bus.in_ready = ~rst & ~skid_full_q;
    assign in_xfer      = bus.in_valid & bus.in_ready;
    assign out_load     = ~out_valid_q | bus.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_reg_d   = out_reg_q;
        out_we_d    = out_we_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_reg_d  = skid_reg_q;
        skid_we_d   = skid_we_q;
        if (out_load) begin
            if (skid_full_q) begin
                // in_ready is low whenever the skid is full, so nothing new arrives here.
                out_valid_d = 1'b1;
                out_data_d  = skid_data_q;
                out_reg_d   = skid_reg_q;
                out_we_d    = skid_we_q;
                skid_full_d = 1'b0;
            end else begin
                out_valid_d = in_xfer;
                if (in_xfer) begin
                    out_data_d = new_data;
                    out_reg_d  = bus.dest_reg;
                    out_we_d   = new_we;
                end
            end
        end else if (in_xfer) begin
            skid_full_d = 1'b1;
            skid_data_d = new_data;
            skid_reg_d  = bus.dest_reg;
            skid_we_d   = new_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_reg_q   <= '0;
            out_we_q    <= 1'b0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_reg_q  <= '0;
            skid_we_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_reg_q   <= out_reg_d;
            out_we_q    <= out_we_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_reg_q  <= skid_reg_d;
            skid_we_q   <= skid_we_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.write_data = out_data_q;
    assign bus.write_reg  = out_reg_q;
    assign bus.write_en   = out_we_q & out_valid_q;
endmodule

// File: tb/tb_writeback_select.sv
// Bench for writeback_select: directed vector table (16- and 32-bit instances),
// backpressure and reset-mid-stall sequences, and a randomized run against a queue model.
module tb_writeback_select;
    localparam int W = 21;  // {write_data[15:0], write_reg[3:0], write_en}

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_select_if #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4)) bus16 ();
    writeback_select_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) bus32 ();

    writeback_select #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    writeback_select #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    typedef struct {
        logic        w32;
        logic [1:0]  src;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] link;
        logic [31:0] imm;
        logic [3:0]  dest;
        logic        rwe;
        logic [31:0] exp_data;
        logic [3:0]  exp_reg;
        logic        exp_we;
    } vec_t;

    vec_t           vecs[16];
    logic [W-1:0]   exp_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w32, input logic [1:0] src, input logic [1:0] size,
                                input logic sgn, input logic [1:0] off, input logic [31:0] alu,
                                input logic [31:0] rd, input logic [31:0] link, input logic [31:0] imm,
                                input logic [3:0] dest, input logic rwe, input logic [31:0] exp_data,
                                input logic [3:0] exp_reg, input logic exp_we);
        vec_t v;
        v.w32 = w32; v.src = src; v.size = size; v.sgn = sgn; v.off = off;
        v.alu = alu; v.rd = rd; v.link = link; v.imm = imm; v.dest = dest; v.rwe = rwe;
        v.exp_data = exp_data; v.exp_reg = exp_reg; v.exp_we = exp_we;
        return v;
    endfunction

    // Reference value from the selection rules using plain shift/mask arithmetic.
    function automatic longint ref_data(input int w, input int src, input int size, input int sgn,
                                        input int off, input longint alu, input longint rd,
                                        input longint link, input longint imm);
        longint lane;
        longint full = (64'd1 << w);
        case (src)
            0: return alu;
            2: return link;
            3: return imm;
            default: begin
                if (size == 0) begin
                    lane = (rd >> (8 * off)) % 256;
                    if (sgn != 0 && lane >= 128) lane = lane + full - 256;
                    return lane;
                end else if (size == 1) begin
                    lane = (rd >> (16 * (off / 2))) % 65536;
                    if (sgn != 0 && lane >= 32768) lane = lane + full - 65536;
                    return lane;
                end
                return rd;
            end
        endcase
    endfunction

    task automatic drive(input vec_t v);
        bus16.wb_src = v.src;        bus32.wb_src = v.src;
        bus16.load_size = v.size;    bus32.load_size = v.size;
        bus16.load_signed = v.sgn;   bus32.load_signed = v.sgn;
        bus16.byte_offset = v.off[0]; bus32.byte_offset = v.off;
        bus16.alu_result = v.alu[15:0]; bus32.alu_result = v.alu;
        bus16.read_data = v.rd[15:0];   bus32.read_data = v.rd;
        bus16.link_addr = v.link[15:0]; bus32.link_addr = v.link;
        bus16.imm_value = v.imm[15:0];  bus32.imm_value = v.imm;
        bus16.dest_reg = v.dest;     bus32.dest_reg = v.dest;
        bus16.reg_write_in = v.rwe;  bus32.reg_write_in = v.rwe;
    endtask

    task automatic check_out16(input string tag, input logic [15:0] d, input logic [3:0] r, input logic we);
        chk({tag, "_valid"}, bus16.out_valid, 1'b1);
        chk({tag, "_data"}, bus16.write_data, d);
        chk({tag, "_reg"}, bus16.write_reg, r);
        chk({tag, "_we"}, bus16.write_en, we);
    endtask

    initial begin
        vec_t v;
        logic will_in, will_out;
        logic [W-1:0] e;
        longint d;

        vecs[0]  = mk(0, 0, 0, 1, 1, 32'h1234, 32'h80F7, 32'h0042, 32'hAB00, 4'd3, 1, 32'h1234, 4'd3, 1);
        vecs[1]  = mk(0, 1, 0, 1, 0, 32'h1111, 32'h80F7, 32'h2222, 32'h3333, 4'd5, 1, 32'hFFF7, 4'd5, 1);
        vecs[2]  = mk(0, 1, 0, 0, 1, 32'h1111, 32'h80F7, 32'h2222, 32'h3333, 4'd6, 1, 32'h0080, 4'd6, 1);
        vecs[3]  = mk(0, 1, 0, 1, 1, 32'h1111, 32'h80F7, 32'h2222, 32'h3333, 4'd7, 1, 32'hFF80, 4'd7, 1);
        vecs[4]  = mk(0, 1, 1, 0, 0, 32'h1111, 32'h80F7, 32'h2222, 32'h3333, 4'd8, 1, 32'h80F7, 4'd8, 1);
        vecs[5]  = mk(0, 1, 3, 1, 1, 32'h1111, 32'h80F7, 32'h2222, 32'h3333, 4'd9, 1, 32'h80F7, 4'd9, 1);
        vecs[6]  = mk(0, 2, 0, 1, 1, 32'h1111, 32'h80F7, 32'h0042, 32'h3333, 4'd1, 1, 32'h0042, 4'd1, 1);
        vecs[7]  = mk(0, 3, 0, 1, 0, 32'h1111, 32'h80F7, 32'h0042, 32'hAB00, 4'd2, 1, 32'hAB00, 4'd2, 1);
        vecs[8]  = mk(0, 0, 0, 0, 0, 32'h5555, 32'h80F7, 32'h0042, 32'hAB00, 4'd0, 1, 32'h5555, 4'd0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 32'h0F0F, 32'h80F7, 32'h0042, 32'hAB00, 4'd7, 0, 32'h0F0F, 4'd7, 0);
        vecs[10] = mk(0, 1, 0, 1, 0, 32'h1111, 32'h7F7F, 32'h2222, 32'h3333, 4'd4, 1, 32'h007F, 4'd4, 1);
        vecs[11] = mk(1, 1, 0, 1, 2, 32'h0, 32'h8899AABB, 32'h1, 32'h2, 4'd3, 1, 32'hFFFFFF99, 4'd3, 1);
        vecs[12] = mk(1, 1, 1, 0, 2, 32'h0, 32'h8899AABB, 32'h1, 32'h2, 4'd4, 1, 32'h00008899, 4'd4, 1);
        vecs[13] = mk(1, 1, 1, 0, 3, 32'h0, 32'h8899AABB, 32'h1, 32'h2, 4'd5, 1, 32'h00008899, 4'd5, 1);
        vecs[14] = mk(1, 1, 1, 1, 0, 32'h0, 32'h8899AABB, 32'h1, 32'h2, 4'd6, 1, 32'hFFFFAABB, 4'd6, 1);
        vecs[15] = mk(1, 1, 2, 1, 3, 32'h0, 32'h8899AABB, 32'h1, 32'h2, 4'd7, 1, 32'h8899AABB, 4'd7, 1);

        // Clock/reset
        drive(vecs[0]);
        bus16.in_valid = 1'b0; bus32.in_valid = 1'b0;
        bus16.out_ready = 1'b1; bus32.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus16.out_valid, 1'b0);
        chk("rst_write_data", bus16.write_data, 16'h0);
        chk("rst_write_reg", bus16.write_reg, 4'h0);
        chk("rst_write_en", bus16.write_en, 1'b0);
        chk("rst_in_ready", bus16.in_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", bus16.in_ready, 1'b1);
        chk("post_rst_out_valid", bus16.out_valid, 1'b0);

        // Directed vector table, one entry at a time with out_ready=1
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            if (vecs[i].w32) bus32.in_valid = 1'b1;
            else             bus16.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus16.in_valid = 1'b0; bus32.in_valid = 1'b0;
            if (vecs[i].w32) begin
                chk($sformatf("vec%0d_valid", i), bus32.out_valid, 1'b1);
                chk($sformatf("vec%0d_data", i), bus32.write_data, vecs[i].exp_data);
                chk($sformatf("vec%0d_reg", i), bus32.write_reg, vecs[i].exp_reg);
                chk($sformatf("vec%0d_we", i), bus32.write_en, vecs[i].exp_we);
            end else begin
                chk($sformatf("vec%0d_valid", i), bus16.out_valid, 1'b1);
                chk($sformatf("vec%0d_data", i), bus16.write_data, vecs[i].exp_data);
                chk($sformatf("vec%0d_reg", i), bus16.write_reg, vecs[i].exp_reg);
                chk($sformatf("vec%0d_we", i), bus16.write_en, vecs[i].exp_we);
            end
        end
        @(negedge clk);
        chk("idle_out_valid", bus16.out_valid, 1'b0);

        // Backpressure: A, B, C back-to-back with out_ready=0
        bus16.out_ready = 1'b0;
        v = vecs[9]; v.alu = 32'hAAAA; v.dest = 4'd1; v.rwe = 1; drive(v);
        bus16.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        check_out16("bp_a0", 16'hAAAA, 4'd1, 1'b1);
        chk("bp_ready_a", bus16.in_ready, 1'b1);
        v.alu = 32'hBBBB; v.dest = 4'd2; drive(v);
        @(posedge clk); @(negedge clk);
        check_out16("bp_a1", 16'hAAAA, 4'd1, 1'b1);
        chk("bp_ready_b", bus16.in_ready, 1'b0);
        v.alu = 32'hCCCC; v.dest = 4'd3; drive(v);
        @(posedge clk); @(negedge clk);
        check_out16("bp_a2", 16'hAAAA, 4'd1, 1'b1);
        chk("bp_ready_c", bus16.in_ready, 1'b0);
        bus16.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check_out16("bp_b", 16'hBBBB, 4'd2, 1'b1);
        chk("bp_ready_drain", bus16.in_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        bus16.in_valid = 1'b0;
        check_out16("bp_c", 16'hCCCC, 4'd3, 1'b1);
        @(posedge clk); @(negedge clk);
        chk("bp_end_valid", bus16.out_valid, 1'b0);

        // Randomized run against the queue model; occupancy = entries accepted but not yet delivered
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            chk("rnd_in_ready", bus16.in_ready, exp_q.size() < 2);
            chk("rnd_out_valid", bus16.out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0 && bus16.out_valid === 1'b1)
                chk("rnd_out", {bus16.write_data, bus16.write_reg, bus16.write_en}, exp_q[0]);
            v.w32 = 0;
            v.src = 2'($urandom_range(0, 3));
            v.size = 2'($urandom_range(0, 3));
            v.sgn = 1'($urandom_range(0, 1));
            v.off = 2'($urandom_range(0, 1));
            v.alu = $urandom; v.rd = $urandom; v.link = $urandom; v.imm = $urandom;
            v.dest = 4'($urandom_range(0, 15));
            v.rwe = 1'($urandom_range(0, 1));
            drive(v);
            bus16.in_valid = ($urandom_range(0, 9) < 7);
            bus16.out_ready = ($urandom_range(0, 9) < 6);
            d = ref_data(16, v.src, v.size, v.sgn, v.off, longint'(v.alu[15:0]), longint'(v.rd[15:0]),
                         longint'(v.link[15:0]), longint'(v.imm[15:0]));
            e = {d[15:0], v.dest, v.rwe && (v.dest != 0)};
            will_in = bus16.in_valid && bus16.in_ready;
            will_out = bus16.out_valid && bus16.out_ready;
            @(posedge clk);
            if (will_out && exp_q.size() > 0) void'(exp_q.pop_front());
            if (will_in) exp_q.push_back(e);
        end
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        chk("rnd_drained", bus16.out_valid, 1'b0);

        // Reset mid-stall: fill output and skid, then pulse rst
        bus16.out_ready = 1'b0;
        v = vecs[0]; v.alu = 32'hD00D; v.dest = 4'd4; drive(v);
        bus16.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        v.alu = 32'hE00E; v.dest = 4'd5; drive(v);
        @(posedge clk); @(negedge clk);
        bus16.in_valid = 1'b0;
        chk("mrst_full_ready", bus16.in_ready, 1'b0);
        chk("mrst_full_valid", bus16.out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mrst_ready_in_rst", bus16.in_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("mrst_valid", bus16.out_valid, 1'b0);
        chk("mrst_data", bus16.write_data, 16'h0);
        chk("mrst_we", bus16.write_en, 1'b0);
        chk("mrst_ready_hold", bus16.in_ready, 1'b0);
        rst = 1'b0;
        bus16.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mrst_ready_after", bus16.in_ready, 1'b1);
        chk("mrst_no_stale0", bus16.out_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("mrst_no_stale1", bus16.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_select.md
Name: writeback_select

Overview:
- Parametrised register-file writeback stage; the next generation of the current memory-to-register select.
- Selects among ALU result, load data, link address and immediate.
- Extracts and sign/zero-extends byte/half loads.
- Registers the result behind a valid/ready handshake with a one-entry skid buffer, so the stage can be stalled by a downstream register file or hazard unit.

Parameters:
DATA_WIDTH, 16, datapath width in bits; multiple of 16
REG_ADDR_WIDTH, 4, register index width
OFF_WIDTH, log2(DATA_WIDTH/8), byte-offset width; derived, not overridden

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry
wb_src  in  2  source select: 0 ALU, 1 MEM, 2 LINK, 3 IMM
load_size  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
load_signed  in  1  1 sign-extend, 0 zero-extend (MEM only)
byte_offset  in  OFF_WIDTH  byte address of the load within read_data
alu_result  in  DATA_WIDTH  ALU result
read_data  in  DATA_WIDTH  data memory read word
link_addr  in  DATA_WIDTH  return address (JAL)
imm_value  in  DATA_WIDTH  pre-shifted immediate (LUI-type)
dest_reg  in  REG_ADDR_WIDTH  destination register index
reg_write_in  in  1  instruction writes a register
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts the output entry
write_data  out  DATA_WIDTH  data to register file
write_reg  out  REG_ADDR_WIDTH  destination index
write_en  out  1  register-file write strobe, qualified by out_valid

Behaviour:
- Reset: one clock; synchronous and active-high.
- Reset values: out_valid=0, write_data=0, write_reg=0, write_en=0, skid empty.
- in_ready=0 while rst is high; in_ready=1 on the first cycle after rst deasserts.
- Reset mid-operation discards both the output and skid entries without a handshake.
- Select/extract is combinational on inputs and captured at transfer time. Inputs are don't-care when in_valid=0.
- MEM, byte: lane = read_data[8*byte_offset +: 8], extended to DATA_WIDTH.
- MEM, half: lane = read_data[16*byte_offset[OFF_WIDTH-1:1] +: 16]; byte_offset[0] is ignored (no misalign trap).
- MEM, word/reserved: read_data unchanged.
- Extension: sign when load_signed=1, else zero. load_size, load_signed and byte_offset are ignored for non-MEM sources.
- write_en = reg_write_in AND (dest_reg != 0). Register 0 is never written; write_reg still carries 0.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Latency: one cycle, transfer to out_valid, when not stalled.
- Throughput: one entry per cycle with out_ready held at 1.
- Output register loads when it is empty or is transferring this cycle. Source: skid if skid full, else the incoming entry.
- Skid loads when an input transfers while the output is full and not transferring.
- in_ready = !skid_full (registered state only; no combinational path from out_ready).
- Simultaneous output transfer and skid full with new input: skid drains to output. in_ready was 0, so no new input is accepted that cycle.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Output fields hold stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset then stream ALU: alu_result=0x1234, dest_reg=3, reg_write_in=1, out_ready=1 -> next cycle out_valid=1, write_data=0x1234, write_reg=3, write_en=1. After rst, all outputs 0.
- Loads, read_data=0x80F7: byte off 0 signed -> 0xFFF7; byte off 1 unsigned -> 0x0080; byte off 1 signed -> 0xFF80; half -> 0x80F7; load_size=3 -> 0x80F7.
- LINK/IMM/r0: wb_src=2, link_addr=0x0042 -> 0x0042; wb_src=3, imm=0xAB00 -> 0xAB00; dest_reg=0 with reg_write_in=1 -> write_en=0, write_reg=0.
- Backpressure: three back-to-back entries A,B,C with out_ready=0:
  - A held on output; B in skid; in_ready=0; C is held upstream.
  - out_ready=1 -> outputs A,B,C in order, one per cycle, with no loss or duplication.
  - Outputs stay stable throughout the stall.
- Reset mid-stall: output and skid full, pulse rst one cycle -> out_valid=0, in_ready=0 during rst then 1; the stalled entries never appear.
- DATA_WIDTH=32 instance: read_data=0x8899AABB:
  - byte off 2 signed -> 0xFFFFFF99; half off 2 unsigned -> 0x00008899; off 3 half -> 0x00008899 (LSB ignored).
